// File: rtl/dig_ct_gen_pkg.sv
// Shared constants and sizing helpers for the truth-table generator and its channels.
package dig_ct_gen_pkg;

    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 8;

    function automatic int unsigned lut_w(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic int unsigned ch_idx_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dig_ct_chan.sv
// One output channel: LUT register, combinational lookup and a saturating toggle counter.
module dig_ct_chan
    import dig_ct_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [lut_w(WIDTH)-1:0] i_data,
    input  logic [WIDTH-1:0]        i_idx,
    output logic                    o_bit,
    input  logic                    i_upd,
    input  logic                    i_new,
    input  logic                    i_cur,
    input  logic                    i_clr,
    output logic [CNT_W-1:0]        o_cnt
);

    localparam int unsigned LW = lut_w(WIDTH);

    logic [LW-1:0]    r_lut;
    logic [CNT_W-1:0] r_cnt;

    // Lookup reads the pre-write LUT, so a sample coincident with a write sees old contents.
    assign o_bit = r_lut[i_idx];
    assign o_cnt = r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lut <= '0;
            r_cnt <= '0;
        end else begin
            if (i_we) begin
                r_lut <= i_data;
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_upd && (i_new != i_cur) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dig_ct_gen.sv
// Multi-channel LUT logic generator: config decode, DEPTH-stage output pipeline, per-channel toggle counts.
module dig_ct_gen
    import dig_ct_gen_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DEPTH    = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              IN,
    input  logic                          IN_VLD,
    input  logic                          CFG_WE,
    input  logic [ch_idx_w(CHANNELS)-1:0] CFG_CH,
    input  logic [lut_w(WIDTH)-1:0]       CFG_DATA,
    input  logic                          CLR_CNT,
    output logic [CHANNELS-1:0]           OUT,
    output logic                          OUT_VLD,
    output logic [CHANNELS*CNT_W-1:0]     TOG_CNT,
    output logic                          CFG_ERR
);

    localparam int unsigned CW = ch_idx_w(CHANNELS);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("dig_ct_gen: DEPTH out of range 1..8");
    end

    logic [CHANNELS-1:0] w_res;
    logic [CHANNELS-1:0] w_stage_in [DEPTH];
    logic [DEPTH-1:0]    w_vld_in;
    logic [CHANNELS-1:0] r_dat [DEPTH];
    logic [DEPTH-1:0]    r_vld;
    logic                r_cfg_err;
    logic                w_cfg_ok;

    assign w_cfg_ok = (32'(CFG_CH) < CHANNELS);

    always_comb begin
        w_stage_in[0] = w_res;
        w_vld_in[0]   = IN_VLD;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_stage_in[k] = r_dat[k-1];
            w_vld_in[k]   = r_vld[k-1];
        end
    end

    // Every stage holds its data when idle, so the last stage doubles as the OUT hold register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld     <= '0;
            r_cfg_err <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld     <= w_vld_in;
            r_cfg_err <= CFG_WE && !w_cfg_ok;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_vld_in[k]) begin
                    r_dat[k] <= w_stage_in[k];
                end
            end
        end
    end

    assign OUT     = r_dat[DEPTH-1];
    assign OUT_VLD = r_vld[DEPTH-1];
    assign CFG_ERR = r_cfg_err;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic w_we;
        assign w_we = CFG_WE && (CFG_CH == CW'(c));

        dig_ct_chan #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_chan (
            .i_clk (CLK),
            .i_rst (RST),
            .i_we  (w_we),
            .i_data(CFG_DATA),
            .i_idx (IN),
            .o_bit (w_res[c]),
            .i_upd (w_vld_in[DEPTH-1]),
            .i_new (w_stage_in[DEPTH-1][c]),
            .i_cur (r_dat[DEPTH-1][c]),
            .i_clr (CLR_CNT),
            .o_cnt (TOG_CNT[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_dig_ct_gen.sv
// Bench for dig_ct_gen: three configurations (DEPTH 1/4/3) against a queue-based reference model.
`timescale 1ns/1ps
module tb_dig_ct_gen;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  IN;
    logic        IN_VLD;
    logic        CFG_WE;
    logic [1:0]  CFG_CH;
    logic [31:0] CFG_DATA;
    logic        CLR_CNT;

    logic [2:0]  out_a, out_b, out_c;
    logic        vld_a, vld_b, vld_c;
    logic        err_a, err_b, err_c;
    logic [23:0] tog_a, tog_c;
    logic [5:0]  tog_b;

    always #5 CLK = ~CLK;

    dig_ct_gen #(.WIDTH(5), .CHANNELS(3), .DEPTH(1), .CNT_W(8)) u_dut_a (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VLD(IN_VLD), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_DATA(CFG_DATA), .CLR_CNT(CLR_CNT), .OUT(out_a), .OUT_VLD(vld_a),
        .TOG_CNT(tog_a), .CFG_ERR(err_a));

    dig_ct_gen #(.WIDTH(5), .CHANNELS(3), .DEPTH(4), .CNT_W(2)) u_dut_b (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VLD(IN_VLD), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_DATA(CFG_DATA), .CLR_CNT(CLR_CNT), .OUT(out_b), .OUT_VLD(vld_b),
        .TOG_CNT(tog_b), .CFG_ERR(err_b));

    dig_ct_gen #(.WIDTH(5), .CHANNELS(3), .DEPTH(3), .CNT_W(8)) u_dut_c (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VLD(IN_VLD), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_DATA(CFG_DATA), .CLR_CNT(CLR_CNT), .OUT(out_c), .OUT_VLD(vld_c),
        .TOG_CNT(tog_c), .CFG_ERR(err_c));

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned dep_of(input int d);
        case (d)
            0: return 1;
            1: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned cmax_of(input int d);
        return (d == 1) ? 3 : 255;
    endfunction

    function automatic logic [2:0] get_out(input int d);
        case (d)
            0: return out_a;
            1: return out_b;
            default: return out_c;
        endcase
    endfunction

    function automatic logic get_vld(input int d);
        case (d)
            0: return vld_a;
            1: return vld_b;
            default: return vld_c;
        endcase
    endfunction

    function automatic logic get_err(input int d);
        case (d)
            0: return err_a;
            1: return err_b;
            default: return err_c;
        endcase
    endfunction

    function automatic int unsigned get_tog(input int d, input int c);
        case (d)
            0: return 32'(tog_a[c*8 +: 8]);
            1: return 32'(tog_b[c*2 +: 2]);
            default: return 32'(tog_c[c*8 +: 8]);
        endcase
    endfunction

    // Reference model: each sample becomes a (due cycle, result) entry in a per-DUT queue.
    typedef struct {
        longint     due;
        logic [2:0] res;
    } item_t;

    item_t       q[3][$];
    item_t       m_it;
    logic [31:0] m_lut [3][3];
    logic [2:0]  m_out [3];
    logic        m_vld [3];
    logic        m_err [3];
    int unsigned m_cnt [3][3];
    longint      cyc = 0;

    always @(posedge CLK) begin
        for (int d = 0; d < 3; d++) begin
            if (RST) begin
                q[d].delete();
                m_out[d] = '0;
                m_vld[d] = 1'b0;
                m_err[d] = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    m_lut[d][c] = '0;
                    m_cnt[d][c] = 0;
                end
            end else begin
                if (IN_VLD) begin
                    m_it.due = cyc + longint'(dep_of(d)) - 1;
                    for (int c = 0; c < 3; c++) m_it.res[c] = m_lut[d][c][IN];
                    q[d].push_back(m_it);
                end
                m_vld[d] = 1'b0;
                if (q[d].size() > 0 && q[d][0].due == cyc) begin
                    m_it = q[d].pop_front();
                    for (int c = 0; c < 3; c++)
                        if (m_it.res[c] != m_out[d][c] && m_cnt[d][c] < cmax_of(d)) m_cnt[d][c]++;
                    m_out[d] = m_it.res;
                    m_vld[d] = 1'b1;
                end
                if (CLR_CNT)
                    for (int c = 0; c < 3; c++) m_cnt[d][c] = 0;
                m_err[d] = CFG_WE && (CFG_CH >= 2'd3);
                if (CFG_WE && CFG_CH < 2'd3) m_lut[d][CFG_CH] = CFG_DATA;
            end
        end
        cyc++;
    end

    always @(negedge CLK) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_vld", d), 32'(get_vld(d)), 32'(m_vld[d]));
            chk($sformatf("d%0d_out", d), 32'(get_out(d)), 32'(m_out[d]));
            chk($sformatf("d%0d_err", d), 32'(get_err(d)), 32'(m_err[d]));
            for (int c = 0; c < 3; c++)
                chk($sformatf("d%0d_tog%0d", d, c), get_tog(d, c), m_cnt[d][c]);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] data);
        CFG_WE = 1'b1; CFG_CH = ch; CFG_DATA = data;
        step();
        CFG_WE = 1'b0;
    endtask

    task automatic sample(input logic [4:0] v);
        IN = v; IN_VLD = 1'b1;
        step();
        IN_VLD = 1'b0;
    endtask

    initial begin
        int first, last, nb;
        RST = 1'b1; IN = '0; IN_VLD = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_DATA = '0; CLR_CNT = 1'b0;
        step(); step();
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_vld_b", 32'(vld_b), 0);
        chk("rst_err_a", 32'(err_a), 0);
        chk("rst_tog_a", 32'(tog_a), 0);
        chk("rst_tog_b", 32'(tog_b), 0);
        RST = 1'b0;

        cfg(2'd0, 32'hFFFF_FFFE);
        cfg(2'd1, 32'h7FFF_FFFF);
        cfg(2'd2, 32'hFFFF_FFFF);
        sample(5'd4);
        chk("basic_vld", 32'(vld_a), 1);
        chk("basic_in4", 32'(out_a), 32'b111);
        sample(5'd0);
        chk("basic_in0", 32'(out_a), 32'b110);
        step();
        chk("hold_vld", 32'(vld_a), 0);
        chk("hold_out", 32'(out_a), 32'b110);
        repeat (4) step();

        // write CH1 := 0 in the same cycle as a sample of IN=0
        CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_DATA = '0; IN = 5'd0; IN_VLD = 1'b1;
        step();
        CFG_WE = 1'b0;
        chk("samecyc_old", 32'(out_a[1]), 1);
        step();
        IN_VLD = 1'b0;
        chk("samecyc_new", 32'(out_a[1]), 0);

        cfg(2'd3, 32'h0);
        chk("cfgerr_hi", 32'(err_a), 1);
        step();
        chk("cfgerr_lo", 32'(err_a), 0);
        sample(5'd0);
        chk("cfgerr_lut0", 32'(out_a), 32'b100);
        sample(5'd4);
        chk("cfgerr_lut4", 32'(out_a), 32'b101);
        repeat (4) step();

        cfg(2'd0, $urandom);
        cfg(2'd1, $urandom);
        cfg(2'd2, $urandom);
        first = -1; last = -1; nb = 0;
        for (int k = 0; k < 16; k++) begin
            IN_VLD = (k < 10);
            IN = 5'($urandom_range(0, 31));
            step();
            if (vld_b) begin
                if (first < 0) first = k;
                last = k;
                nb++;
            end
        end
        IN_VLD = 1'b0;
        chk("pipe_first", 32'(first), 3);
        chk("pipe_last", 32'(last), 12);
        chk("pipe_count", 32'(nb), 10);

        RST = 1'b1; step(); RST = 1'b0;
        cfg(2'd0, 32'h0000_0002);
        for (int k = 0; k < 6; k++) begin
            IN = (k % 2 == 0) ? 5'd1 : 5'd0;
            IN_VLD = 1'b1;
            step();
        end
        IN_VLD = 1'b0;
        repeat (4) step();
        chk("tog_sat_b", 32'(tog_b[1:0]), 3);
        chk("tog_six_a", 32'(tog_a[7:0]), 6);
        chk("tog_six_c", 32'(tog_c[7:0]), 6);
        IN = 5'd1; IN_VLD = 1'b1; CLR_CNT = 1'b1;
        step();
        IN_VLD = 1'b0; CLR_CNT = 1'b0;
        chk("clr_wins_a", 32'(tog_a[7:0]), 0);
        chk("clr_out_a", 32'(out_a[0]), 1);
        chk("clr_b", 32'(tog_b[1:0]), 0);
        repeat (3) step();
        chk("post_clr_b", 32'(tog_b[1:0]), 1);

        IN = 5'd1; IN_VLD = 1'b1;
        step(); step();
        IN_VLD = 1'b0; RST = 1'b1;
        step();
        RST = 1'b0;
        chk("flush_out_c", 32'(out_c), 0);
        chk("flush_tog_c", 32'(tog_c), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("flush_vld_c%0d", k), 32'(vld_c), 0);
            chk($sformatf("flush_vldb_%0d", k), 32'(vld_b), 0);
        end

        for (int k = 0; k < 400; k++) begin
            IN       = 5'($urandom_range(0, 31));
            IN_VLD   = ($urandom_range(0, 3) != 0);
            CFG_WE   = ($urandom_range(0, 9) == 0);
            CFG_CH   = 2'($urandom_range(0, 3));
            CFG_DATA = $urandom;
            CLR_CNT  = ($urandom_range(0, 29) == 0);
            RST      = ($urandom_range(0, 99) == 0);
            step();
        end
        IN_VLD = 1'b0; CFG_WE = 1'b0; CLR_CNT = 1'b0; RST = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
